// File: rtl/bit_reverser_stream_if.sv
// Valid/ready stream bundle for the bit/byte reorder engine.
// master = producer+consumer side, slave = engine side.
interface bit_reverser_stream_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/bit_reverser_stream.sv
// Two-stage streaming bit/byte reorder engine with valid/ready backpressure.
// Define BITREV_CNT_EN to add the xfer_cnt completed-transfer counter port.
module bit_reverser_stream #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  bit_reverser_stream_if.slave bus,
  output logic                 busy
`ifdef BITREV_CNT_EN
  ,
  output logic [15:0]          xfer_cnt
`endif
);

  localparam int NB = WIDTH / 8;

  if (WIDTH < 8 || (WIDTH % 8) != 0) begin : g_width_chk
    $error("bit_reverser_stream: WIDTH must be a multiple of 8 and >= 8");
  end

  function automatic logic [WIDTH-1:0] xform(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       m
  );
    logic [WIDTH-1:0] r;
    r = d;
    unique case (m)
      2'b01: begin
        for (int i = 0; i < WIDTH; i++)
          r[i] = d[WIDTH-1-i];
      end
      2'b10: begin
        for (int k = 0; k < NB; k++)
          r[8*k +: 8] = d[8*(NB-1-k) +: 8];
      end
      2'b11: begin
        for (int k = 0; k < NB; k++)
          for (int j = 0; j < 8; j++)
            r[8*k+j] = d[8*k+7-j];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [1:0]       s1_mode;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic             s2_adv;
  logic             in_fire;

  // Ready never looks at in_valid, so the producer sees no comb loop.
  assign s2_adv       = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_adv;
  assign in_fire      = bus.in_valid && bus.in_ready;

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign busy          = s1_valid || s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= '0;
    end else begin
      if (in_fire) begin
        s1_data <= bus.in_data;
        s1_mode <= bus.in_mode;
      end
      s1_valid <= in_fire || (s1_valid && !s2_adv);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid)
        s2_data <= xform(s1_data, s1_mode);
    end
  end

`ifdef BITREV_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      xfer_cnt <= '0;
    else if (s2_valid && bus.out_ready)
      xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bit_reverser_stream.sv
// Directed bench for bit_reverser_stream: WIDTH=16 modes, stall,
// async reset, exhaustive WIDTH=8 sweep, optional counter wrap.
module tb_bit_reverser_stream;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic busy8;

  always #5 clk = ~clk;

  bit_reverser_stream_if #(.WIDTH(16)) bus ();
  bit_reverser_stream_if #(.WIDTH(8))  bus8 ();

`ifdef BITREV_CNT_EN
  logic [15:0] xfer_cnt;
  logic [15:0] xfer_cnt8;
`endif

  bit_reverser_stream #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy)
`ifdef BITREV_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  bit_reverser_stream #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus8),
    .busy     (busy8)
`ifdef BITREV_CNT_EN
    ,
    .xfer_cnt (xfer_cnt8)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] got[$];
  logic [7:0]  got8[$];
  logic [7:0]  exp8[$];
  bit          mon_en = 1'b1;

  always @(negedge clk)
    if (mon_en && bus.out_valid && bus.out_ready)
      got.push_back(bus.out_data);

  always @(negedge clk)
    if (bus8.out_valid && bus8.out_ready)
      got8.push_back(bus8.out_data);

  typedef struct {
    logic [15:0] din;
    logic [1:0]  mode;
    logic [15:0] exp;
  } vec_t;

  localparam int NV = 9;
  vec_t tbl[NV];
  logic [15:0] bp_exp[8];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref8(input logic [7:0] d,
                                      input logic [1:0] m);
    logic [7:0] r;
    r = {<<{d}};
    case (m)
      2'b01, 2'b11: return r;
      default:      return d;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c;
    int idx;
    bit acc;
    logic [15:0] held;

    tbl[0] = '{16'h1234, 2'b00, 16'h1234};
    tbl[1] = '{16'h1234, 2'b01, 16'h2C48};
    tbl[2] = '{16'h1234, 2'b10, 16'h3412};
    tbl[3] = '{16'h1234, 2'b11, 16'h482C};
    tbl[4] = '{16'h0001, 2'b01, 16'h8000};
    tbl[5] = '{16'h00FF, 2'b10, 16'hFF00};
    tbl[6] = '{16'h8001, 2'b11, 16'h0180};
    tbl[7] = '{16'hA5C3, 2'b01, 16'hC3A5};
    tbl[8] = '{16'hF00F, 2'b00, 16'hF00F};

    bp_exp = '{16'h8000, 16'h4000, 16'hC000, 16'h2000,
               16'hA000, 16'h6000, 16'hE000, 16'h1000};

    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_mode    = '0;
    bus.out_ready  = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.in_data   = '0;
    bus8.in_mode   = '0;
    bus8.out_ready = 1'b0;

    rst = 1'b1;
    #3;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", bus.in_ready, 1);
`ifdef BITREV_CNT_EN
    check("rst_xfer_cnt", xfer_cnt, 0);
`endif
    tick();
    rst = 1'b0;

    // all four modes back-to-back with the sink always ready
    got.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = tbl[i].din;
      bus.in_mode  = tbl[i].mode;
      tick();
      if (i == 0)
        check("lat_first_empty", bus.out_valid, 0);
      if (i == 1) begin
        check("lat_first_valid", bus.out_valid, 1);
        check("lat_first_data", bus.out_data, tbl[0].exp);
      end
      if (i >= 2)
        check("tput_valid", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (got.size() < NV && n < 20) begin
      tick();
      n++;
    end
    check("mode_count", got.size(), NV);
    for (int i = 0; i < NV && i < got.size(); i++)
      check($sformatf("mode_vec%0d", i), got[i], tbl[i].exp);
    tick();
    check("empty_busy", busy, 0);
    check("empty_in_ready", bus.in_ready, 1);
    check("empty_out_valid", bus.out_valid, 0);
    check("empty_out_data_kept", bus.out_data, tbl[NV-1].exp);

    // backpressure: sink stalls five cycles mid-stream
    got.delete();
    idx  = 0;
    c    = 0;
    held = '0;
    while (idx < 8 && c < 100) begin
      bus.out_ready = !(c >= 3 && c < 8);
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'(idx + 1);
      bus.in_mode   = 2'b01;
      #1;
      acc = bus.in_ready;
      if (c == 7)
        check("bp_in_ready_low", bus.in_ready, 0);
      if (c == 4)
        held = bus.out_data;
      if (c > 4 && c < 8) begin
        check("bp_hold_valid", bus.out_valid, 1);
        check("bp_hold_data", bus.out_data, held);
      end
      tick();
      if (acc)
        idx++;
      c++;
    end
    check("bp_all_accepted", idx, 8);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (got.size() < 8 && n < 20) begin
      tick();
      n++;
    end
    tick();
    check("bp_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      check($sformatf("bp_vec%0d", i), got[i], bp_exp[i]);

    // reset with both stages full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h1111;
    bus.in_mode   = 2'b00;
    tick();
    bus.in_data   = 16'h2222;
    tick();
    bus.in_valid  = 1'b0;
    check("mid_busy", busy, 1);
    check("mid_in_ready", bus.in_ready, 0);
    rst = 1'b1;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_data", bus.out_data, 0);
    check("arst_busy", busy, 0);
    tick();
    rst = 1'b0;
    got.delete();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h00FF;
    bus.in_mode   = 2'b10;
    tick();
    bus.in_valid  = 1'b0;
    check("post_rst_lat1", bus.out_valid, 0);
    tick();
    check("post_rst_valid", bus.out_valid, 1);
    check("post_rst_data", bus.out_data, 16'hFF00);
    tick();
    check("post_rst_one_beat", got.size(), 1);
    check("post_rst_idle", busy, 0);

    // WIDTH=8: every value in every mode with a random sink
    idx = 0;
    c   = 0;
    while (idx < 1024 && c < 20000) begin
      bus8.out_ready = 1'($urandom_range(0, 1));
      bus8.in_valid  = 1'b1;
      bus8.in_data   = idx[7:0];
      bus8.in_mode   = idx[9:8];
      #1;
      acc = bus8.in_ready;
      if (acc)
        exp8.push_back(ref8(idx[7:0], idx[9:8]));
      tick();
      if (acc)
        idx++;
      c++;
    end
    check("w8_all_accepted", idx, 1024);
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    n = 0;
    while (got8.size() < exp8.size() && n < 20) begin
      tick();
      n++;
    end
    check("w8_count", got8.size(), exp8.size());
    for (int i = 0; i < exp8.size() && i < got8.size(); i++)
      check($sformatf("w8_vec%0d", i), got8[i], exp8[i]);

`ifdef BITREV_CNT_EN
    // 65537 transfers must wrap the counter around to 1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("cnt_reset", xfer_cnt, 0);
    mon_en        = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h5A5A;
    bus.in_mode   = 2'b00;
    n = 0;
    c = 0;
    while (n < 65537 && c < 70000) begin
      if (bus.out_valid)
        n++;
      tick();
      c++;
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    #1;
    check("cnt_transfers", n, 65537);
    check("cnt_wrap", xfer_cnt, 16'h0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
